// File: rtl/mp3_sci_writer_if.sv
// Command port and SCI decoder pins shared by the write engine and its peers.
// slave: the write engine; master: requester plus decoder side.
interface mp3_sci_writer_if;
  logic        CMD_REQ;
  logic [7:0]  CMD_ADDR;
  logic [15:0] CMD_DATA;
  logic        CMD_ACK;
  logic        MP3_DREQ;
  logic        MP3_XCS;
  logic        MP3_SCK;
  logic        MP3_SI;

  modport slave (
    input  CMD_REQ, CMD_ADDR, CMD_DATA, MP3_DREQ,
    output CMD_ACK, MP3_XCS, MP3_SCK, MP3_SI
  );

  modport master (
    output CMD_REQ, CMD_ADDR, CMD_DATA, MP3_DREQ,
    input  CMD_ACK, MP3_XCS, MP3_SCK, MP3_SI
  );
endinterface

// File: rtl/mp3_sci_writer.sv
// Round-robin SCI write engine (command port vs. volume): 32-bit frame, MSB first.
// Grant->WAIT_DREQ 1 cycle, 64 shift cycles, GAP_CYCLES gap; stalls in WAIT_DREQ while MP3_DREQ=0.
module mp3_sci_writer #(
  parameter int          GAP_CYCLES   = 4,
  parameter logic [7:0]  SCI_VOL_ADDR = 8'h0B
) (
  input  logic             MP3_SCLK,
  input  logic             RESET,
  input  logic [7:0]       VOLUME,
  mp3_sci_writer_if.slave  sci,
  output logic             BUSY
);
  typedef enum logic [1:0] {IDLE, WAIT_DREQ, SHIFT, GAP} state_t;

  localparam logic [7:0] SCI_WRITE_OP = 8'h02;
  localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);
  localparam logic       GAP_ONE      = (GAP_CYCLES == 1);

  state_t      state;
  logic [31:0] frame;
  logic [4:0]  bit_idx;
  logic        phase;
  logic [7:0]  gap_cnt;
  logic [7:0]  vol_shadow;
  logic        vol_dirty;
  logic        last_grant_cmd;
  logic        grant_cmd;
  logic        xcs_q;
  logic        sck_q;
  logic        si_q;
  logic        ack_q;
  logic        cmd_wins;

  // Command takes the bus when alone, or on a tie when volume went last.
  always_comb begin
    cmd_wins = sci.CMD_REQ && (!vol_dirty || !last_grant_cmd);
  end

  always_ff @(posedge MP3_SCLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      frame          <= '0;
      bit_idx        <= '0;
      phase          <= 1'b0;
      gap_cnt        <= '0;
      vol_shadow     <= 8'h00;
      vol_dirty      <= 1'b1;
      last_grant_cmd <= 1'b0;
      grant_cmd      <= 1'b0;
      xcs_q          <= 1'b1;
      sck_q          <= 1'b0;
      si_q           <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (VOLUME != vol_shadow) begin
        vol_dirty <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cmd_wins) begin
            frame          <= {SCI_WRITE_OP, sci.CMD_ADDR, sci.CMD_DATA};
            last_grant_cmd <= 1'b1;
            grant_cmd      <= 1'b1;
            state          <= WAIT_DREQ;
          end else if (vol_dirty) begin
            frame          <= {SCI_WRITE_OP, SCI_VOL_ADDR, VOLUME, VOLUME};
            vol_shadow     <= VOLUME;
            vol_dirty      <= 1'b0;
            last_grant_cmd <= 1'b0;
            grant_cmd      <= 1'b0;
            state          <= WAIT_DREQ;
          end
        end
        WAIT_DREQ: begin
          if (sci.MP3_DREQ) begin
            state   <= SHIFT;
            bit_idx <= 5'd31;
            phase   <= 1'b0;
            xcs_q   <= 1'b0;
            sck_q   <= 1'b0;
            si_q    <= frame[31];
          end
        end
        SHIFT: begin
          if (!phase) begin
            phase <= 1'b1;
            sck_q <= 1'b1;
          end else if (bit_idx == 5'd0) begin
            state   <= GAP;
            xcs_q   <= 1'b1;
            sck_q   <= 1'b0;
            gap_cnt <= GAP_LAST;
            ack_q   <= grant_cmd && GAP_ONE;
          end else begin
            bit_idx <= bit_idx - 5'd1;
            phase   <= 1'b0;
            sck_q   <= 1'b0;
            si_q    <= frame[bit_idx - 5'd1];
          end
        end
        GAP: begin
          // ack is raised so it lands on the final gap cycle
          if (gap_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
            ack_q   <= grant_cmd && (gap_cnt == 8'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sci.MP3_XCS = xcs_q;
  assign sci.MP3_SCK = sck_q;
  assign sci.MP3_SI  = si_q;
  assign sci.CMD_ACK = ack_q;
  assign BUSY        = (state != IDLE);
endmodule
